// File: rtl/aes_mm_fifo_intf_pkg.sv
// aes_intf_pkg: shared definitions for the AES Avalon-MM FIFO front end.
//   - register byte addresses (DIN / DOUT / STATUS / CTRL)
//   - STATUS and CTRL bit positions
//   - block type and a helper that extracts one 32-bit word of a block,
//     MSW first (word 0 = bits [127:96])
package aes_intf_pkg;

    localparam logic [3:0] ADDR_DIN    = 4'h0;
    localparam logic [3:0] ADDR_DOUT   = 4'h4;
    localparam logic [3:0] ADDR_STATUS = 4'h8;
    localparam logic [3:0] ADDR_CTRL   = 4'hC;

    localparam int ST_IN_FULL   = 16;
    localparam int ST_OUT_EMPTY = 17;
    localparam int ST_BUSY      = 18;
    localparam int ST_DIN_PART  = 19;
    localparam int ST_DOUT_PART = 20;
    localparam int ST_ERR       = 24;

    localparam int CTRL_FLUSH   = 0;
    localparam int CTRL_CLR_ERR = 1;
    localparam int CTRL_IRQ_EN  = 2;

    localparam int WORDS_PER_BLK = 4;
    localparam logic [1:0] LAST_WORD = 2'(WORDS_PER_BLK - 1);

    typedef logic [127:0] blk_t;

    // Word idx of a block, word 0 being the most significant.
    function automatic logic [31:0] blk_word(input blk_t b, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = b[127:96];
            2'd1:    w = b[95:64];
            2'd2:    w = b[63:32];
            default: w = b[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/aes_mm_fifo_intf_if.sv
// aes_mm_fifo_intf_if: bundles the Avalon-MM slave bus and the AES core
// valid/ready streams of aes_mm_fifo_intf.
//   slave  : view of the front end (accepts bus accesses, drives the core input
//            stream, accepts the core result stream)
//   master : view of the environment (host bus master plus AES core)
interface aes_mm_fifo_intf_if;
    import aes_intf_pkg::*;

    logic        chipselect;
    logic [3:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        irq;
    logic        core_in_valid;
    logic        core_in_ready;
    blk_t        core_in_data;
    logic        core_out_valid;
    logic        core_out_ready;
    blk_t        core_out_data;

    modport slave (
        input  chipselect, address, write, writedata, read,
        output readdata, waitrequest, irq,
        output core_in_valid, core_in_data,
        input  core_in_ready,
        input  core_out_valid, core_out_data,
        output core_out_ready
    );

    modport master (
        output chipselect, address, write, writedata, read,
        input  readdata, waitrequest, irq,
        input  core_in_valid, core_in_data,
        output core_in_ready,
        output core_out_valid, core_out_data,
        input  core_out_ready
    );

endinterface

// File: rtl/aes_mm_fifo_intf_blk_fifo.sv
// aes_blk_fifo: synchronous 128-bit block FIFO.
//   clock, resetn : clock, synchronous active-low reset
//   clr           : synchronous flush (empties the queue)
//   push, din     : enqueue; accepted when not full, or when full and popping
//   pop, dout     : dequeue; dout is the current head (undefined when empty)
//   full, empty   : occupancy flags
//   count         : number of stored blocks
module aes_blk_fifo
    import aes_intf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     clr,
    input  logic                     push,
    input  blk_t                     din,
    input  logic                     pop,
    output blk_t                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    blk_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     cnt;
    logic            do_push;
    logic            do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    // A pop in the same cycle frees the slot a push into a full queue needs.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clock) begin
        if (!resetn || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/aes_mm_fifo_intf.sv
// aes_mm_fifo_intf: Avalon-MM slave front end for an AES-128 block core.
//   clock, resetn : clock, synchronous active-low reset (shared with the core)
//   bus (slave)   : Avalon-MM registers DIN 0x0, DOUT 0x4, STATUS 0x8, CTRL 0xC,
//                   zero-latency readdata, waitrequest, level irq; plus the
//                   core_in_* / core_out_* valid/ready block streams.
// Four DIN writes build one block (MSW first) into the input queue; queued
// blocks are issued to the core one at a time; results are queued and read
// back as four DOUT words.
module aes_mm_fifo_intf
    import aes_intf_pkg::*;
#(
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4,
    parameter int CNT_W     = $clog2((IN_DEPTH > OUT_DEPTH) ? IN_DEPTH : OUT_DEPTH) + 1
) (
    input  logic            clock,
    input  logic            resetn,
    aes_mm_fifo_intf_if.slave bus
);

    localparam int IN_CW  = $clog2(IN_DEPTH) + 1;
    localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;

    logic [1:0]        k;          // next DIN word index
    logic [1:0]        j;          // next DOUT word index
    logic              busy;       // one block outstanding at the core
    logic              drop;       // discard the outstanding result (flushed)
    logic              err;
    logic              irq_en;
    logic              irq_q;
    logic [95:0]       asm_q;      // DIN words 0..2 of the block being built

    logic              in_push, in_pop, in_full, in_empty;
    logic [IN_CW-1:0]  in_cnt;
    blk_t              in_head;
    logic              out_push, out_pop, out_full, out_empty;
    logic [OUT_CW-1:0] out_cnt;
    blk_t              out_head;

    logic              wr_sel, rd_sel, din_stall, dout_stall, stall;
    logic              din_wr, ctrl_wr, flush, dout_rd, dout_ok, dout_err;
    logic              cin_valid, cout_ready, in_fire, out_fire;
    logic [31:0]       status, rdata;

    // Bus decode: write wins when both strobes are set.
    assign wr_sel = bus.chipselect & bus.write;
    assign rd_sel = bus.chipselect & bus.read & ~bus.write;

    // Last DIN word waits for input space; DOUT read waits for a result that
    // is still on its way (queued or in the core).
    assign din_stall  = wr_sel & (bus.address == ADDR_DIN) & (k == LAST_WORD) & in_full;
    assign dout_stall = rd_sel & (bus.address == ADDR_DOUT) & out_empty & (~in_empty | busy);
    assign stall      = din_stall | dout_stall;

    assign din_wr   = wr_sel & ~stall & (bus.address == ADDR_DIN);
    assign ctrl_wr  = wr_sel & ~stall & (bus.address == ADDR_CTRL);
    assign flush    = ctrl_wr & bus.writedata[CTRL_FLUSH];
    assign dout_rd  = rd_sel & ~stall & (bus.address == ADDR_DOUT);
    assign dout_ok  = dout_rd & ~out_empty;
    assign dout_err = dout_rd & out_empty;

    // Core streams. A DOUT pop of the last word frees room for a result now.
    assign cin_valid  = ~in_empty & ~busy;
    assign in_fire    = cin_valid & bus.core_in_ready;
    assign out_pop    = dout_ok & (j == LAST_WORD);
    assign cout_ready = ~out_full | drop | out_pop;
    assign out_fire   = bus.core_out_valid & cout_ready;
    assign out_push   = out_fire & ~drop & ~flush;
    assign in_push    = din_wr & (k == LAST_WORD) & ~flush;
    assign in_pop     = in_fire;

    aes_blk_fifo #(.DEPTH(IN_DEPTH)) u_in_fifo (
        .clock  (clock),
        .resetn (resetn),
        .clr    (flush),
        .push   (in_push),
        .din    ({asm_q, bus.writedata}),
        .pop    (in_pop),
        .dout   (in_head),
        .full   (in_full),
        .empty  (in_empty),
        .count  (in_cnt)
    );

    aes_blk_fifo #(.DEPTH(OUT_DEPTH)) u_out_fifo (
        .clock  (clock),
        .resetn (resetn),
        .clr    (flush),
        .push   (out_push),
        .din    (bus.core_out_data),
        .pop    (out_pop),
        .dout   (out_head),
        .full   (out_full),
        .empty  (out_empty),
        .count  (out_cnt)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            k      <= '0;
            j      <= '0;
            busy   <= 1'b0;
            drop   <= 1'b0;
            err    <= 1'b0;
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (flush)       k <= '0;
            else if (din_wr) k <= k + 1'b1;

            if (flush)        j <= '0;
            else if (dout_ok) j <= j + 1'b1;

            if (dout_err)                                    err <= 1'b1;
            else if (ctrl_wr && bus.writedata[CTRL_CLR_ERR]) err <= 1'b0;

            if (ctrl_wr) irq_en <= bus.writedata[CTRL_IRQ_EN];

            if (in_fire)       busy <= 1'b1;
            else if (out_fire) busy <= 1'b0;

            // Drop whatever will still be outstanding after this cycle,
            // including a block the core accepts in the flush cycle itself.
            if (flush)         drop <= (busy & ~out_fire) | in_fire;
            else if (out_fire) drop <= 1'b0;

            irq_q <= irq_en & (out_cnt != '0);
        end
    end

    always_ff @(posedge clock) begin
        if (din_wr) begin
            case (k)
                2'd0:    asm_q[95:64] <= bus.writedata;
                2'd1:    asm_q[63:32] <= bus.writedata;
                2'd2:    asm_q[31:0]  <= bus.writedata;
                default: asm_q        <= asm_q;
            endcase
        end
    end

    always_comb begin
        status                 = '0;
        status[CNT_W-1:0]      = CNT_W'(in_cnt);
        status[8 +: CNT_W]     = CNT_W'(out_cnt);
        status[ST_IN_FULL]     = in_full;
        status[ST_OUT_EMPTY]   = out_empty;
        status[ST_BUSY]        = busy;
        status[ST_DIN_PART]    = (k != '0);
        status[ST_DOUT_PART]   = (j != '0);
        status[ST_ERR]         = err;
    end

    always_comb begin
        rdata = '0;
        if (rd_sel) begin
            case (bus.address)
                ADDR_DOUT:   if (!out_empty) rdata = blk_word(out_head, j);
                ADDR_STATUS: rdata = status;
                ADDR_CTRL:   rdata[CTRL_IRQ_EN] = irq_en;
                default:     rdata = '0;
            endcase
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign bus.readdata       = resetn ? rdata : '0;
    assign bus.waitrequest    = resetn & stall;
    assign bus.irq            = irq_q;
    assign bus.core_in_valid  = resetn & cin_valid;
    assign bus.core_in_data   = (resetn && !in_empty) ? in_head : '0;
    assign bus.core_out_ready = resetn & cout_ready;

endmodule
